// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches one instruction per req/gnt + rvalid transaction and
// presents it to decode with a valid/ready handshake. Redirects flush and drain stale responses.
module instruction_fetch #(
    parameter int                   WORDSIZE         = 64,
    parameter int                   INSTRUCTION_SIZE = 32,
    parameter logic [WORDSIZE-1:0]  RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        if_imem_req,
    output logic [WORDSIZE-1:0]         if_imem_addr,
    input  logic                        if_imem_gnt,
    input  logic                        if_imem_rvalid,
    input  logic [INSTRUCTION_SIZE-1:0] if_imem_rdata,
    output logic [INSTRUCTION_SIZE-1:0] if_instruction,
    output logic [WORDSIZE-1:0]         if_pc,
    output logic                        if_valid,
    input  logic                        if_ready,
    input  logic                        if_redirect,
    input  logic [WORDSIZE-1:0]         if_redirect_pc,
    output logic                        if_misaligned
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    localparam logic [INSTRUCTION_SIZE-1:0] NOP = INSTRUCTION_SIZE'(32'h0000_0013);
    localparam logic [WORDSIZE-1:0]         PC_STEP = WORDSIZE'(4);

    logic [2:0]                  state_q, state_d;
    logic [WORDSIZE-1:0]         pc_q, pc_d;
    logic [INSTRUCTION_SIZE-1:0] instr_q, instr_d;
    logic [WORDSIZE-1:0]         ipc_q, ipc_d;
    logic                        misaligned_q, misaligned_d;
    logic                        redirect_live;

    // Redirects are only honoured once fetching has started and before a halt.
    assign redirect_live = if_redirect && (state_q != S_IDLE) && (state_q != S_HALT);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        ipc_d        = ipc_q;
        misaligned_d = misaligned_q;

        if (redirect_live) begin
            if (if_redirect_pc[1:0] != 2'b00) begin
                misaligned_d = 1'b1;
                state_d      = S_HALT;
            end else begin
                pc_d = if_redirect_pc;
                // A granted-but-unanswered request must have its response drained.
                case (state_q)
                    S_REQ:   state_d = if_imem_gnt    ? S_DRAIN : S_REQ;
                    S_WAIT:  state_d = if_imem_rvalid ? S_REQ   : S_DRAIN;
                    S_HOLD:  state_d = S_REQ;
                    S_DRAIN: state_d = if_imem_rvalid ? S_REQ   : S_DRAIN;
                    default: state_d = state_q;
                endcase
            end
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_REQ;
                S_REQ:   if (if_imem_gnt) state_d = S_WAIT;
                S_WAIT: begin
                    if (if_imem_rvalid) begin
                        instr_d = if_imem_rdata;
                        ipc_d   = pc_q;
                        pc_d    = pc_q + PC_STEP;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD:  if (if_ready) state_d = S_REQ;
                S_DRAIN: if (if_imem_rvalid) state_d = S_REQ;
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= NOP;
            ipc_q        <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            ipc_q        <= ipc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign if_imem_req    = (state_q == S_REQ);
    assign if_imem_addr   = pc_q;
    assign if_valid       = (state_q == S_HOLD);
    assign if_instruction = instr_q;
    assign if_pc          = ipc_q;
    assign if_misaligned  = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: two instances, one at RESET_PC=0 and one at the
// top of the address space to exercise PC wrap.
module tb_instruction_fetch;

    localparam logic [63:0] NOP     = 64'h13;
    localparam logic [63:0] TOP_PC  = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A
    logic        rst_n, gnt, rvalid, ready, redirect;
    logic [31:0] rdata;
    logic [63:0] redirect_pc;
    logic        req, valid, misaligned;
    logic [63:0] addr, ipc;
    logic [31:0] instr;

    // Instance B (wrap)
    logic        b_rst_n, b_gnt, b_rvalid, b_ready;
    logic [31:0] b_rdata;
    logic        b_req, b_valid, b_misaligned;
    logic [63:0] b_addr, b_ipc;
    logic [31:0] b_instr;

    instruction_fetch #(.WORDSIZE(64), .INSTRUCTION_SIZE(32), .RESET_PC(64'h0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_imem_req(req), .if_imem_addr(addr), .if_imem_gnt(gnt),
        .if_imem_rvalid(rvalid), .if_imem_rdata(rdata),
        .if_instruction(instr), .if_pc(ipc), .if_valid(valid), .if_ready(ready),
        .if_redirect(redirect), .if_redirect_pc(redirect_pc), .if_misaligned(misaligned)
    );

    instruction_fetch #(.WORDSIZE(64), .INSTRUCTION_SIZE(32), .RESET_PC(TOP_PC)) u_dut_wrap (
        .clk(clk), .rst_n(b_rst_n),
        .if_imem_req(b_req), .if_imem_addr(b_addr), .if_imem_gnt(b_gnt),
        .if_imem_rvalid(b_rvalid), .if_imem_rdata(b_rdata),
        .if_instruction(b_instr), .if_pc(b_ipc), .if_valid(b_valid), .if_ready(b_ready),
        .if_redirect(1'b0), .if_redirect_pc(64'h0), .if_misaligned(b_misaligned)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0; rdata = '0;
        b_rst_n = 1'b0; b_gnt = 1'b0; b_rvalid = 1'b0; b_ready = 1'b0; b_rdata = '0;
        tick(); tick();

        // Reset state
        chk("rst_req",   req,        0);
        chk("rst_addr",  addr,       0);
        chk("rst_valid", valid,      0);
        chk("rst_instr", instr,      NOP);
        chk("rst_pc",    ipc,        0);
        chk("rst_mis",   misaligned, 0);

        // 1: zero-wait fetch
        rst_n = 1'b1; gnt = 1'b1;
        tick();                                   // IDLE -> REQ
        chk("t1_req_c1",  req,  1);
        chk("t1_addr_c1", addr, 0);
        tick();                                   // REQ -> WAIT
        chk("t1_req_c2",   req,   0);
        chk("t1_valid_c2", valid, 0);
        rvalid = 1'b1; rdata = 32'h00A00093;
        tick();                                   // WAIT -> HOLD
        chk("t1_valid_c3", valid, 1);
        chk("t1_instr",    instr, 64'h00A00093);
        chk("t1_ipc",      ipc,   0);
        chk("t1_req_c3",   req,   0);
        rvalid = 1'b0; ready = 1'b1;
        tick();                                   // HOLD -> REQ
        chk("t1_req_next",  req,   1);
        chk("t1_addr_next", addr,  4);
        chk("t1_valid_off", valid, 0);

        // 2: decode back-pressure
        ready = 1'b0;
        tick();                                   // REQ -> WAIT
        rvalid = 1'b1; rdata = 32'h00100113;
        tick();                                   // WAIT -> HOLD
        rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", valid, 1);
            chk("t2_instr", instr, 64'h00100113);
            chk("t2_ipc",   ipc,   4);
            chk("t2_req",   req,   0);
            tick();
        end
        ready = 1'b1;
        tick();                                   // HOLD -> REQ
        chk("t2_req",  req,  1);
        chk("t2_addr", addr, 8);
        ready = 1'b0;

        // 3: redirect while waiting, stale response drained
        tick();                                   // REQ -> WAIT
        redirect = 1'b1; redirect_pc = 64'h100;
        tick();                                   // WAIT -> DRAIN
        redirect = 1'b0;
        chk("t3_req_drain",   req,   0);
        chk("t3_valid_drain", valid, 0);
        chk("t3_addr_drain",  addr,  64'h100);
        tick();                                   // stay DRAIN
        chk("t3_req_drain2",  req,   0);
        rvalid = 1'b1; rdata = 32'hDEADBEEF;
        tick();                                   // DRAIN -> REQ
        rvalid = 1'b0;
        chk("t3_req",   req,   1);
        chk("t3_addr",  addr,  64'h100);
        chk("t3_valid", valid, 0);
        chk("t3_instr", instr, 64'h00100113);

        // 4: redirect coincident with rvalid
        tick();                                   // REQ -> WAIT
        redirect = 1'b1; redirect_pc = 64'h200; rvalid = 1'b1; rdata = 32'h11111111;
        tick();                                   // WAIT -> REQ, pc = 0x200
        redirect = 1'b0; rvalid = 1'b0;
        chk("t4_req",   req,   1);
        chk("t4_addr",  addr,  64'h200);
        chk("t4_valid", valid, 0);
        tick();                                   // REQ -> WAIT
        rvalid = 1'b1; rdata = 32'h00000513;
        tick();                                   // WAIT -> HOLD
        rvalid = 1'b0;
        chk("t4_ipc",   ipc,   64'h200);
        chk("t4_instr", instr, 64'h00000513);
        ready = 1'b1;
        tick();                                   // HOLD -> REQ
        ready = 1'b0;
        chk("t4_addr_next", addr, 64'h204);

        // 5: misaligned redirect halts until reset
        gnt = 1'b0; redirect = 1'b1; redirect_pc = 64'h102;
        tick();
        chk("t5_mis",   misaligned, 1);
        chk("t5_req",   req,        0);
        chk("t5_valid", valid,      0);
        chk("t5_addr",  addr,       64'h204);
        redirect_pc = 64'h300;
        gnt = 1'b1; rvalid = 1'b1; ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            redirect = (i % 2 == 0);
            tick();
            chk("t5_halt_req",   req,        0);
            chk("t5_halt_valid", valid,      0);
            chk("t5_halt_mis",   misaligned, 1);
            chk("t5_halt_addr",  addr,       64'h204);
        end
        redirect = 1'b0; gnt = 1'b0; rvalid = 1'b0; ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_mis",  misaligned, 0);
        chk("t5_rst_addr", addr,       0);

        // 6: PC wrap and async reset in WAIT
        tick();
        b_rst_n = 1'b1; b_gnt = 1'b1;
        tick();                                   // IDLE -> REQ
        chk("t6_req",  b_req,  1);
        chk("t6_addr", b_addr, TOP_PC);
        tick();                                   // REQ -> WAIT
        b_rvalid = 1'b1; b_rdata = 32'h00000013;
        tick();                                   // WAIT -> HOLD
        b_rvalid = 1'b0;
        chk("t6_valid", b_valid, 1);
        chk("t6_ipc",   b_ipc,   TOP_PC);
        b_ready = 1'b1;
        tick();                                   // HOLD -> REQ
        b_ready = 1'b0;
        chk("t6_wrap_req",  b_req,  1);
        chk("t6_wrap_addr", b_addr, 0);
        b_rdata = 32'h12345678;
        tick();                                   // REQ -> WAIT
        chk("t6_wait_req", b_req, 0);
        #2 b_rst_n = 1'b0;
        #1;
        chk("t6_rst_req",   b_req,        0);
        chk("t6_rst_addr",  b_addr,       TOP_PC);
        chk("t6_rst_valid", b_valid,      0);
        chk("t6_rst_instr", b_instr,      NOP);
        chk("t6_rst_ipc",   b_ipc,        TOP_PC);
        chk("t6_rst_mis",   b_misaligned, 0);
        // A late response after reset release lands in IDLE/REQ and is ignored.
        b_rvalid = 1'b1; b_gnt = 1'b0;
        tick();
        b_rst_n = 1'b1;
        tick();                                   // IDLE -> REQ
        chk("t6_late_valid", b_valid, 0);
        chk("t6_late_req",   b_req,   1);
        tick();                                   // stay REQ (no gnt)
        chk("t6_late_valid2", b_valid, 0);
        chk("t6_late_instr",  b_instr, NOP);
        b_rvalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
